frame_cropper: RTL

Removes a fixed border (TOP/BOTTOM/LEFT/RIGHT pixels) from an AXI4-Stream video frame. It is the inverse of `frame_extender`: it sits after window-based filters that ran on an extended frame and restores the original resolution. It regenerates `tuser` (start of frame) and `tlast` (end of line) for the cropped geometry. Full throughput, one output register stage, backpressure honoured.

---
 rtl/img_proc_pkg.sv | 6 +
 rtl/frame_pos_counter.sv | 52 +++++
 rtl/frame_cropper.sv | 85 ++++++++
 3 files changed

// File: rtl/img_proc_pkg.sv
// img_proc_pkg: shared helpers for the image processing stream blocks
package img_proc_pkg;
  function automatic int tdata_width(input int px_width);
    return ((px_width + 7) / 8) * 8;
  endfunction
endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: tracks the x/y position of accepted stream beats from tuser/tlast
module frame_pos_counter #(
  parameter int RES_X = 1922,
  parameter int RES_Y = 1082,
  parameter int X_W   = $clog2(RES_X),
  parameter int Y_W   = $clog2(RES_Y)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           beat_i,
  input  logic           sof_i,
  input  logic           eol_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           line_err_o
);
  localparam logic [X_W-1:0] X_MAX = X_W'(RES_X - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(RES_Y - 1);
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic sat_q, sat_d, err_q, err_d, sat;
  // tuser forces the current beat to (0,0) regardless of where the counters were
  assign x_o = sof_i ? '0 : x_q;
  assign y_o = sof_i ? '0 : y_q;
  assign sat = !sof_i && sat_q;
  assign line_err_o = err_q;
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    sat_d = sat_q;
    err_d = 1'b0;
    if (beat_i) begin
      x_d = eol_i ? '0 : (x_o == X_MAX ? X_MAX : x_o + 1'b1);
      y_d = eol_i ? (y_o == Y_MAX ? '0 : y_o + 1'b1) : y_o;
      sat_d = !eol_i && x_o == X_MAX;
      err_d = eol_i ? x_o != X_MAX : (x_o == X_MAX && !sat);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
      sat_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      sat_q <= sat_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/frame_cropper.sv
// frame_cropper: strips a fixed border from a video stream and regenerates tuser/tlast
module frame_cropper
  import img_proc_pkg::*;
#(
  parameter int TOP         = 1,
  parameter int BOTTOM      = 1,
  parameter int LEFT        = 1,
  parameter int RIGHT       = 1,
  parameter int FRAME_RES_X = 1922,
  parameter int FRAME_RES_Y = 1082,
  parameter int PX_WIDTH    = 8,
  parameter int TDATA_WIDTH = tdata_width(PX_WIDTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [TDATA_WIDTH-1:0]   s_tdata_i,
  input  logic                     s_tvalid_i,
  input  logic                     s_tuser_i,
  input  logic                     s_tlast_i,
  output logic                     s_tready_o,
  output logic [TDATA_WIDTH-1:0]   m_tdata_o,
  output logic                     m_tvalid_o,
  output logic                     m_tuser_o,
  output logic                     m_tlast_o,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep_o,
  output logic [TDATA_WIDTH/8-1:0] m_tstrb_o,
  input  logic                     m_tready_i,
  output logic                     line_err_o
);
  localparam int X_CNT_W = $clog2(FRAME_RES_X);
  localparam int Y_CNT_W = $clog2(FRAME_RES_Y);
  localparam logic [X_CNT_W-1:0] X_FIRST_KEEP = X_CNT_W'(LEFT);
  localparam logic [Y_CNT_W-1:0] Y_FIRST_KEEP = Y_CNT_W'(TOP);
  localparam logic [X_CNT_W-1:0] X_LAST_KEEP = X_CNT_W'(FRAME_RES_X - RIGHT - 1);
  localparam logic [Y_CNT_W-1:0] Y_LAST_KEEP = Y_CNT_W'(FRAME_RES_Y - BOTTOM - 1);
  logic [X_CNT_W-1:0] x;
  logic [Y_CNT_W-1:0] y;
  logic keep, load;
  logic tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  frame_pos_counter #(
    .RES_X(FRAME_RES_X),
    .RES_Y(FRAME_RES_Y),
    .X_W  (X_CNT_W),
    .Y_W  (Y_CNT_W)
  ) u_pos (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .beat_i    (s_tvalid_i && s_tready_o),
    .sof_i     (s_tuser_i),
    .eol_i     (s_tlast_i),
    .x_o       (x),
    .y_o       (y),
    .line_err_o(line_err_o)
  );
  assign keep = x >= X_FIRST_KEEP && x <= X_LAST_KEEP && y >= Y_FIRST_KEEP && y <= Y_LAST_KEEP;
  // border beats are swallowed even while the output register is stalled
  assign s_tready_o = !keep || !tvalid_q || m_tready_i;
  assign load = s_tvalid_i && s_tready_o && keep;
  always_comb begin
    tvalid_d = load || (tvalid_q && !m_tready_i);
    tdata_d = load ? s_tdata_i : tdata_q;
    tuser_d = load ? (x == X_FIRST_KEEP && y == Y_FIRST_KEEP) : tuser_q;
    tlast_d = load ? (x == X_LAST_KEEP || s_tlast_i) : tlast_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tvalid_q <= 1'b0;
      tdata_q <= '0;
      tuser_q <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
      tlast_q <= tlast_d;
    end
  end
  assign m_tvalid_o = tvalid_q;
  assign m_tdata_o = tdata_q;
  assign m_tuser_o = tuser_q;
  assign m_tlast_o = tlast_q;
  assign m_tkeep_o = '1;
  assign m_tstrb_o = '1;
endmodule
